vmul_seq: RTL and testbench

Issue sequencer for the vector multiply datapath. Accepts one multiply command per operation and computes the number of 64-bit beats from `vl` and `sew`. Streams beat read addresses to the vector register file and drives `valid`, `sew` and `opSel` into the operand selector and multiplier array. Tracks each beat through the fixed-latency multiply pipeline and issues writebacks with tail byte enables, then signals completion.

---
 rtl/vmul_pkg.sv | 45 ++++
 rtl/vmul_seq_if.sv | 50 +++++
 rtl/vmul_wb_delay.sv | 34 +++
 rtl/vmul_seq.sv | 137 +++++++++++++
 tb/tb_vmul_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmul_pkg.sv
// Shared types and helpers for the vector multiply issue sequencer.
package vmul_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Element width encodings carried on sew.
    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    // Widest vl the helpers accept; narrower vl fields are zero-extended.
    localparam int VL_MAX_WIDTH = 16;

    // Beat count and tail byte count of one command.
    typedef struct packed {
        logic [VL_MAX_WIDTH-1:0] n;
        logic [2:0]              tail;
    } beat_info_t;

    // bytes = vl << sew; n = ceil(bytes / 8); tail = bytes mod 8.
    function automatic beat_info_t beat_count(input logic [VL_MAX_WIDTH-1:0] vl,
                                              input logic [1:0] sew);
        logic [VL_MAX_WIDTH+2:0] bytes;
        beat_info_t              res;
        bytes    = {3'b000, vl} << sew;
        res.tail = bytes[2:0];
        res.n    = bytes[VL_MAX_WIDTH+2:3] + {{(VL_MAX_WIDTH-1){1'b0}}, |bytes[2:0]};
        return res;
    endfunction

    // Byte enables of the last beat: low 'tail' bytes, or all bytes when tail is 0.
    function automatic logic [7:0] tail_mask(input logic [2:0] tail);
        logic [7:0] m;
        if (tail == 3'd0) m = 8'hFF;
        else              m = (8'd1 << tail) - 8'd1;
        return m;
    endfunction

endpackage

// File: rtl/vmul_seq_if.sv
// Command, VRF read, multiplier control, writeback and status signals of vmul_seq.
// Handshake: a command transfers on a clk edge where req_valid and req_ready are both
// high; req_* must be stable while req_valid is high; req_valid without req_ready is
// ignored and nothing downstream ever stalls the sequencer.
interface vmul_seq_if #(
    parameter int ADDR_WIDTH  = 5,
    parameter int VL_WIDTH    = 11,
    parameter int SEW_WIDTH   = 2,
    parameter int OPSEL_WIDTH = 2,
    parameter int BE_WIDTH    = 8
) ();
    import vmul_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [VL_WIDTH-1:0]    req_vl;
    logic [SEW_WIDTH-1:0]   req_sew;
    logic [OPSEL_WIDTH-1:0] req_opsel;
    logic [ADDR_WIDTH-1:0]  req_vs1;
    logic [ADDR_WIDTH-1:0]  req_vs2;
    logic [ADDR_WIDTH-1:0]  req_vd;
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr_a;
    logic [ADDR_WIDTH-1:0]  rd_addr_b;
    logic                   mul_valid;
    logic [SEW_WIDTH-1:0]   mul_sew;
    logic [OPSEL_WIDTH-1:0] mul_opsel;
    logic                   wb_en;
    logic [ADDR_WIDTH-1:0]  wb_addr;
    logic [BE_WIDTH-1:0]    wb_be;
    logic                   busy;
    logic                   done;
    logic                   err;
    state_t                 state;

    // Sequencer side.
    modport slave (
        input  req_valid, req_vl, req_sew, req_opsel, req_vs1, req_vs2, req_vd,
        output req_ready, rd_en, rd_addr_a, rd_addr_b, mul_valid, mul_sew, mul_opsel,
        output wb_en, wb_addr, wb_be, busy, done, err, state
    );

    // Command issuer / observer side.
    modport master (
        output req_valid, req_vl, req_sew, req_opsel, req_vs1, req_vs2, req_vd,
        input  req_ready, rd_en, rd_addr_a, rd_addr_b, mul_valid, mul_sew, mul_opsel,
        input  wb_en, wb_addr, wb_be, busy, done, err, state
    );

endinterface

// File: rtl/vmul_wb_delay.sv
// Fixed-depth shift register carrying writeback tags alongside the multiply pipeline.
module vmul_wb_delay #(
    parameter int DEPTH      = 5,
    parameter int ADDR_WIDTH = 5,
    parameter int BE_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [BE_WIDTH-1:0]   out_be,
    output logic                  out_last
);
    localparam int W = 1 + ADDR_WIDTH + BE_WIDTH + 1;

    logic [W-1:0] stage [DEPTH];

    // Shift one stage per cycle; clear drops every tag in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= {in_valid, in_addr, in_be, in_last};
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign {out_valid, out_addr, out_be, out_last} = stage[DEPTH-1];

endmodule

// File: rtl/vmul_seq.sv
// Issue sequencer: splits a multiply command into 64-bit beats, streams VRF reads,
// drives the multiplier controls and retires tagged writebacks after PIPE_LAT.
module vmul_seq
    import vmul_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int VL_WIDTH      = 11,
    parameter int SEW_WIDTH     = 2,
    parameter int OPSEL_WIDTH   = 2,
    parameter int PIPE_LAT      = 4,
    parameter int ENABLE_64_BIT = 1
) (
    input  logic      clk,
    input  logic      rst,
    vmul_seq_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    // One extra stage covers the VRF read cycle ahead of the multiplier.
    localparam int DEPTH    = PIPE_LAT + 1;

    state_t                 state, state_next;
    logic [SEW_WIDTH-1:0]   sew_q;
    logic [OPSEL_WIDTH-1:0] opsel_q;
    logic [ADDR_WIDTH-1:0]  vs1_q, vs2_q, vd_q;
    logic [VL_WIDTH-1:0]    n_q, idx_q;
    logic [2:0]             tail_q;
    logic                   mul_valid_q, short_done_q, err_q;

    beat_info_t             info;
    logic                   ready, handshake, illegal, n_zero, last_beat, issue, busy;
    logic [ADDR_WIDTH-1:0]  beat_off;
    logic                   dly_valid, dly_last;
    logic [ADDR_WIDTH-1:0]  dly_addr;
    logic [BE_WIDTH-1:0]    dly_be;

    assign info      = beat_count(VL_MAX_WIDTH'(bus.req_vl), 2'(bus.req_sew));
    assign n_zero    = (info.n == '0);
    assign illegal   = (ENABLE_64_BIT == 0) && (2'(bus.req_sew) == SEW_64);
    assign ready     = (state == IDLE) && !rst;
    assign handshake = bus.req_valid && ready;
    assign last_beat = (idx_q == n_q - VL_WIDTH'(1));
    assign beat_off  = ADDR_WIDTH'(idx_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state plus read strobe and busy flag.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (handshake && !illegal && !n_zero) state_next = ISSUE;
            end
            ISSUE: begin
                issue = 1'b1;
                if (last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if (dly_valid && dly_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, beat counter and the one-cycle pulses of commands with no beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            sew_q        <= '0;
            opsel_q      <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            vd_q         <= '0;
            n_q          <= '0;
            tail_q       <= '0;
            idx_q        <= '0;
            mul_valid_q  <= 1'b0;
            short_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mul_valid_q  <= issue;
            short_done_q <= handshake && (illegal || n_zero);
            err_q        <= handshake && illegal;
            if (handshake) begin
                sew_q   <= bus.req_sew;
                opsel_q <= bus.req_opsel;
                vs1_q   <= bus.req_vs1;
                vs2_q   <= bus.req_vs2;
                vd_q    <= bus.req_vd;
                n_q     <= info.n[VL_WIDTH-1:0];
                tail_q  <= info.tail;
                idx_q   <= '0;
            end else if (issue) begin
                idx_q <= idx_q + VL_WIDTH'(1);
            end
        end
    end

    vmul_wb_delay #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_wb_delay (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (issue),
        .in_addr   (issue ? vd_q + beat_off : '0),
        .in_be     (issue ? (last_beat ? tail_mask(tail_q) : '1) : '0),
        .in_last   (issue && last_beat),
        .out_valid (dly_valid),
        .out_addr  (dly_addr),
        .out_be    (dly_be),
        .out_last  (dly_last)
    );

    assign bus.req_ready = ready;
    assign bus.rd_en     = issue;
    assign bus.rd_addr_a = issue ? vs1_q + beat_off : '0;
    assign bus.rd_addr_b = issue ? vs2_q + beat_off : '0;
    assign bus.mul_valid = mul_valid_q;
    assign bus.mul_sew   = busy ? sew_q : '0;
    assign bus.mul_opsel = busy ? opsel_q : '0;
    assign bus.wb_en     = dly_valid;
    assign bus.wb_addr   = dly_addr;
    assign bus.wb_be     = dly_be;
    assign bus.busy      = busy;
    assign bus.done      = (dly_valid && dly_last) || short_done_q;
    assign bus.err       = err_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_vmul_seq.sv
// Bench for vmul_seq: dut_a has 64-bit elements enabled, dut_b (same stimulus) has them disabled.
module tb_vmul_seq;
  import vmul_pkg::*;

  localparam int PL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vmul_seq_if bus_a ();
  vmul_seq_if bus_b ();

  vmul_seq #(.PIPE_LAT(PL), .ENABLE_64_BIT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  vmul_seq #(.PIPE_LAT(PL), .ENABLE_64_BIT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.req_valid = bus_a.req_valid;
  assign bus_b.req_vl    = bus_a.req_vl;
  assign bus_b.req_sew   = bus_a.req_sew;
  assign bus_b.req_opsel = bus_a.req_opsel;
  assign bus_b.req_vs1   = bus_a.req_vs1;
  assign bus_b.req_vs2   = bus_a.req_vs2;
  assign bus_b.req_vd    = bus_a.req_vd;

  // ---------------- scoreboard ----------------
  logic [41:0] rd_q[$];    // {cycle, addr_a, addr_b}
  logic [31:0] mv_q[$];    // cycle
  logic [45:0] wb_q[$];    // {cycle, addr, be, last}
  logic [32:0] dn_q[$];    // {cycle, err}
  logic [32:0] dn_b_q[$];  // {cycle, err} for dut_b
  int busy_from = 1;
  int busy_to = 0;
  logic [1:0] sew_exp = '0;
  logic [1:0] opsel_exp = '0;
  bit mon_en = 1'b0;
  int rdb_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int q_total();
    return rd_q.size() + mv_q.size() + wb_q.size() + dn_q.size() + dn_b_q.size();
  endfunction

  // Per-cycle monitor: status outputs against the window model, events against the queues.
  always @(negedge clk) begin : mon
    logic e_busy;
    logic [41:0] r;
    logic [31:0] m;
    logic [45:0] w;
    logic [32:0] d;
    if (mon_en) begin
      e_busy = (cyc >= busy_from) && (cyc <= busy_to);
      check("busy", bus_a.busy, e_busy);
      check("req_ready", bus_a.req_ready, !e_busy && !rst);
      check("mul_sew", bus_a.mul_sew, e_busy ? sew_exp : 2'd0);
      check("mul_opsel", bus_a.mul_opsel, e_busy ? opsel_exp : 2'd0);
      check("err_a", bus_a.err, 0);
      check("err_b_alone", bus_b.err & ~bus_b.done, 0);
      if (bus_a.rd_en) begin
        if (rd_q.size() == 0) check("rd_extra", bus_a.rd_en, 0);
        else begin
          r = rd_q.pop_front();
          check("rd_cycle", cyc, r[41:10]);
          check("rd_addr_a", bus_a.rd_addr_a, r[9:5]);
          check("rd_addr_b", bus_a.rd_addr_b, r[4:0]);
        end
      end
      if (bus_a.mul_valid) begin
        if (mv_q.size() == 0) check("mv_extra", bus_a.mul_valid, 0);
        else begin
          m = mv_q.pop_front();
          check("mv_cycle", cyc, m);
        end
      end
      if (bus_a.wb_en) begin
        if (wb_q.size() == 0) check("wb_extra", bus_a.wb_en, 0);
        else begin
          w = wb_q.pop_front();
          check("wb_cycle", cyc, w[45:14]);
          check("wb_addr", bus_a.wb_addr, w[13:9]);
          check("wb_be", bus_a.wb_be, w[8:1]);
          check("wb_done", bus_a.done, w[0]);
        end
      end
      if (bus_a.done) begin
        if (dn_q.size() == 0) check("done_extra", bus_a.done, 0);
        else begin
          d = dn_q.pop_front();
          check("done_cycle", cyc, d[32:1]);
          check("done_err", bus_a.err, d[0]);
        end
      end
      if (bus_b.done) begin
        if (dn_b_q.size() == 0) check("b_done_extra", bus_b.done, 0);
        else begin
          d = dn_b_q.pop_front();
          check("b_done_cycle", cyc, d[32:1]);
          check("b_err", bus_b.err, d[0]);
        end
      end
      if (bus_b.rd_en) rdb_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int vl, input int sew, input int opsel,
                      input int vs1, input int vs2, input int vd);
    int t, bytes, n, tail, guard;
    logic [7:0] be;
    guard = 0;
    while (bus_a.req_ready !== 1'b1 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_accept", bus_a.req_ready, 1);
    if (bus_a.req_ready !== 1'b1) return;
    bus_a.req_valid = 1'b1;
    bus_a.req_vl    = 11'(vl);
    bus_a.req_sew   = 2'(sew);
    bus_a.req_opsel = 2'(opsel);
    bus_a.req_vs1   = 5'(vs1);
    bus_a.req_vs2   = 5'(vs2);
    bus_a.req_vd    = 5'(vd);
    t = cyc;
    bytes = vl * (1 << sew);
    n = (bytes + 7) / 8;
    tail = bytes % 8;
    for (int i = 0; i < n; i++) begin
      be = (i == n - 1 && tail != 0) ? (8'hFF >> (8 - tail)) : 8'hFF;
      rd_q.push_back({32'(t + 1 + i), 5'(vs1 + i), 5'(vs2 + i)});
      mv_q.push_back(32'(t + 2 + i));
      wb_q.push_back({32'(t + 2 + PL + i), 5'(vd + i), be, 1'(i == n - 1)});
    end
    if (n > 0) begin
      busy_from = t + 1;
      busy_to = t + n + 1 + PL;
      sew_exp = 2'(sew);
      opsel_exp = 2'(opsel);
      dn_q.push_back({32'(t + n + 1 + PL), 1'b0});
    end else begin
      dn_q.push_back({32'(t + 1), 1'b0});
    end
    if (sew == 3) dn_b_q.push_back({32'(t + 1), 1'b1});
    else if (n > 0) dn_b_q.push_back({32'(t + n + 1 + PL), 1'b0});
    else dn_b_q.push_back({32'(t + 1), 1'b0});
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
  endtask

  // Synchronous reset: flush pending expectations once rst is sampled, check cleared outputs.
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rd_q.delete(); mv_q.delete(); wb_q.delete(); dn_q.delete(); dn_b_q.delete();
    busy_to = -1;
    @(negedge clk);
    check("rst_rd_en", bus_a.rd_en, 0);
    check("rst_rd_addr_a", bus_a.rd_addr_a, 0);
    check("rst_mul_valid", bus_a.mul_valid, 0);
    check("rst_mul_sew", bus_a.mul_sew, 0);
    check("rst_wb_en", bus_a.wb_en, 0);
    check("rst_wb_addr", bus_a.wb_addr, 0);
    check("rst_wb_be", bus_a.wb_be, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_err", bus_a.err, 0);
    check("rst_ready", bus_a.req_ready, 0);
    check("rst_b_done", bus_b.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((q_total() != 0 || cyc <= busy_to + 1) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_left", q_total(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt0;
    bus_a.req_valid = 1'b0;
    bus_a.req_vl = '0;
    bus_a.req_sew = '0;
    bus_a.req_opsel = '0;
    bus_a.req_vs1 = '0;
    bus_a.req_vs2 = '0;
    bus_a.req_vd = '0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    mon_en = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus_a.req_ready, 1);
    @(posedge clk); #1;

    // single beat, full byte enables
    send(8, 0, 1, 2, 10, 20);
    wait_idle();
    // two beats, tail of 2 bytes
    send(5, 1, 2, 3, 4, 7);
    wait_idle();
    // empty command
    send(0, 2, 3, 1, 1, 1);
    wait_idle();
    // sew=3: legal on dut_a (4 beats), illegal on dut_b (err, no reads)
    cnt0 = rdb_cnt;
    send(4, 3, 0, 5, 6, 9);
    wait_idle();
    check("b_no_reads", rdb_cnt - cnt0, 0);
    // address wrap on reads and writebacks
    send(16, 2, 1, 31, 17, 30);
    wait_idle();
    // back-to-back with mixed tails
    send(3, 0, 0, 0, 8, 16);
    send(7, 2, 3, 4, 12, 24);
    send(1, 3, 2, 9, 9, 9);
    wait_idle();
    // reset in the middle of an 8-beat command, then a fresh command
    send(16, 2, 1, 0, 8, 16);
    @(posedge clk); #1;
    @(posedge clk); #1;
    apply_reset();
    send(9, 1, 2, 2, 3, 4);
    wait_idle();
    // random commands
    for (int k = 0; k < 24; k++) begin
      send(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      repeat (int'($urandom_range(0, 2))) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
